// File: rtl/shiftregister_monitor_circular_right5_if.sv
// Interface bundling the shift-register observation inputs and the monitor's status outputs.
// The monitor sits on the slave modport; whatever drives the observed register uses master.
interface shiftregister_monitor_circular_right5_if #(
  parameter int LAP_WIDTH = 4
);
  logic                 preset_enable;
  logic [4:0]           signal_q;
  logic [4:0]           signal_q_;
  logic [2:0]           phase;
  logic [LAP_WIDTH-1:0] lap_count;
  logic                 locked;
  logic                 sync_pulse;
  logic                 error;

  modport master (
    output preset_enable, signal_q, signal_q_,
    input  phase, lap_count, locked, sync_pulse, error
  );

  modport slave (
    input  preset_enable, signal_q, signal_q_,
    output phase, lap_count, locked, sync_pulse, error
  );
endinterface

// File: rtl/shiftregister_monitor_circular_right5.sv
// Checker for a 5-bit circular right-shift register: locks on the preset, tracks phase and laps.
// Optional macro SHIFTMON_RESYNC_EN makes FAULT a one-cycle state that recaptures on its own.
//
// state | meaning
// IDLE  | waiting for the first preset_enable after reset
// ARM   | preset is being loaded; capture it on the first edge without preset_enable
// TRACK | locked, compare signal_q/signal_q_ against the predicted rotation every edge
// FAULT | a mismatch was seen; error is held
module shiftregister_monitor_circular_right5 #(
  parameter int LAP_WIDTH = 4
) (
  input logic                                   clockpulse,
  input logic                                   clear_,
  shiftregister_monitor_circular_right5_if.slave mon
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_TRACK = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t               state;
  logic [4:0]           expected;
  logic [2:0]           phase_r;
  logic [LAP_WIDTH-1:0] lap_r;
  logic                 locked_r;
  logic                 sync_r;
  logic                 error_r;
  logic                 mismatch;

  function automatic logic [4:0] rotr(input logic [4:0] x);
    return {x[0], x[4:1]};
  endfunction

  // Both the value and its complement rail must agree for a cycle to count as a match.
  assign mismatch = (mon.signal_q != expected) || (mon.signal_q_ != ~mon.signal_q);

  always_ff @(posedge clockpulse or negedge clear_) begin
    if (!clear_) begin
      state    <= ST_IDLE;
      expected <= 5'b00000;
      phase_r  <= 3'd0;
      lap_r    <= '0;
      locked_r <= 1'b0;
      sync_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      sync_r <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (mon.preset_enable) state <= ST_ARM;
        end
        ST_ARM: begin
          if (!mon.preset_enable) begin
            expected <= rotr(mon.signal_q);
            phase_r  <= 3'd0;
            lap_r    <= '0;
            error_r  <= 1'b0;
            locked_r <= 1'b1;
            state    <= ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (mon.preset_enable) begin
            locked_r <= 1'b0;
            state    <= ST_ARM;
          end else if (mismatch) begin
            error_r  <= 1'b1;
            locked_r <= 1'b0;
            state    <= ST_FAULT;
          end else begin
            expected <= rotr(expected);
            if (phase_r == 3'd4) begin
              phase_r <= 3'd0;
              lap_r   <= lap_r + 1'b1;
              sync_r  <= 1'b1;
            end else begin
              phase_r <= phase_r + 3'd1;
            end
          end
        end
        ST_FAULT: begin
          if (mon.preset_enable) begin
            state <= ST_ARM;
          end
`ifdef SHIFTMON_RESYNC_EN
          else begin
            // Recapture whatever the register holds now; lap history is kept.
            expected <= rotr(mon.signal_q);
            phase_r  <= 3'd0;
            error_r  <= 1'b0;
            locked_r <= 1'b1;
            state    <= ST_TRACK;
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mon.phase      = phase_r;
  assign mon.lap_count  = lap_r;
  assign mon.locked     = locked_r;
  assign mon.sync_pulse = sync_r;
  assign mon.error      = error_r;

endmodule

// File: tb/tb_shiftregister_monitor_circular_right5.sv
// Bench for shiftregister_monitor_circular_right5: a source register model with fault injection,
// a match-count reference model, directed scenarios and a randomized soak.
module tb_shiftregister_monitor_circular_right5;
  localparam int LW = 4;
  localparam int M_IDLE = 0, M_ARM = 1, M_TRACK = 2, M_FAULT = 3;

  logic clk = 1'b0;
  logic clear_ = 1'b0;
  always #5 clk = ~clk;

  shiftregister_monitor_circular_right5_if #(.LAP_WIDTH(LW)) bus ();

  shiftregister_monitor_circular_right5 #(.LAP_WIDTH(LW)) dut (
    .clockpulse (clk),
    .clear_     (clear_),
    .mon        (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  logic [4:0] sr = 5'b00000;

  // Reference: everything since the last capture is described by the captured
  // value and the number of matching cycles seen after it.
  int         m_mode = M_IDLE;
  logic [4:0] m_base = 5'b00000;
  int         m_n = 0;
  int         m_lap_base = 0;
  bit         m_err = 1'b0, m_locked = 1'b0, m_sync = 1'b0;

  function automatic logic [4:0] rotk(input logic [4:0] x, input int k);
    logic [9:0] xx;
    xx = {x, x} >> (k % 5);
    return xx[4:0];
  endfunction

  function automatic int m_phase();
    return m_n % 5;
  endfunction

  function automatic int m_lap();
    return (m_lap_base + m_n / 5) % (1 << LW);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_base = 5'b00000; m_n = 0; m_lap_base = 0;
    m_err = 1'b0; m_locked = 1'b0; m_sync = 1'b0;
  endtask

  task automatic model_step(input bit pe, input logic [4:0] q, input logic [4:0] qn);
    m_sync = 1'b0;
    case (m_mode)
      M_IDLE: if (pe) m_mode = M_ARM;
      M_ARM: if (!pe) begin
        m_base = q; m_n = 0; m_lap_base = 0; m_err = 1'b0; m_locked = 1'b1; m_mode = M_TRACK;
      end
      M_TRACK: begin
        if (pe) begin
          m_mode = M_ARM; m_locked = 1'b0;
        end else if (q != rotk(m_base, m_n + 1) || qn != ~q) begin
          m_mode = M_FAULT; m_err = 1'b1; m_locked = 1'b0;
        end else begin
          m_n = m_n + 1;
          if (m_n % 5 == 0) m_sync = 1'b1;
        end
      end
      default: begin
        if (pe) m_mode = M_ARM;
`ifdef SHIFTMON_RESYNC_EN
        else begin
          m_lap_base = m_lap(); m_base = q; m_n = 0;
          m_err = 1'b0; m_locked = 1'b1; m_mode = M_TRACK;
        end
`endif
      end
    endcase
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  // One clock of the source register: drive at negedge, let it load or rotate at posedge.
  task automatic cycle(input bit pe, input logic [4:0] pre, input logic [4:0] qm, input logic [4:0] cm);
    @(negedge clk);
    bus.preset_enable = pe;
    bus.signal_q      = sr ^ qm;
    bus.signal_q_     = ~sr ^ cm;
    @(posedge clk);
    if (clear_) model_step(pe, bus.signal_q, bus.signal_q_);
    sr = pe ? pre : rotk(sr, 1);
    #2;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 5'b00000, 5'b00000, 5'b00000);
  endtask

  always @(posedge clk) begin
    #1;
    if (clear_ && cmp_en) begin
      check("phase",      int'(bus.phase),      m_phase());
      check("lap_count",  int'(bus.lap_count),  m_lap());
      check("locked",     int'(bus.locked),     int'(m_locked));
      check("sync_pulse", int'(bus.sync_pulse), int'(m_sync));
      check("error",      int'(bus.error),      int'(m_err));
    end
  end

  initial begin
    int ph_exp[5] = '{1, 2, 3, 4, 0};
    bus.preset_enable = 1'b0;
    bus.signal_q      = 5'b00000;
    bus.signal_q_     = 5'b11111;
    model_reset();
    #12;
    check("rst_phase",  int'(bus.phase), 0);
    check("rst_lap",    int'(bus.lap_count), 0);
    check("rst_locked", int'(bus.locked), 0);
    check("rst_sync",   int'(bus.sync_pulse), 0);
    check("rst_error",  int'(bus.error), 0);
    @(negedge clk);
    clear_ = 1'b1;
    cmp_en = 1'b1;

    // Lock and track on preset 11000.
    cycle(1'b1, 5'b11000, 5'b00000, 5'b00000);
    check("lock_e1_locked", int'(bus.locked), 0);
    idle_cycles(1);
    check("lock_e2_locked", int'(bus.locked), 1);
    check("lock_e2_phase", int'(bus.phase), 0);
    for (int i = 0; i < 5; i++) begin
      idle_cycles(1);
      check("lock_phase_seq", int'(bus.phase), ph_exp[i]);
    end
    check("lock_sync", int'(bus.sync_pulse), 1);
    check("lock_lap", int'(bus.lap_count), 1);

    // Long run: 15 edges total since the preset edge.
    idle_cycles(8);
    check("long_lap", int'(bus.lap_count), 2);
    check("long_phase", int'(bus.phase), 3);
    check("long_error", int'(bus.error), 0);

    // Advance to phase 2 and corrupt 00011 into 00111.
    idle_cycles(4);
    check("pre_corrupt_phase", int'(bus.phase), 2);
    check("pre_corrupt_q", int'(sr), 5'b00011);
    cycle(1'b0, 5'b00000, 5'b00100, 5'b00000);
    check("corrupt_error", int'(bus.error), 1);
    check("corrupt_locked", int'(bus.locked), 0);
    check("corrupt_phase", int'(bus.phase), 2);
`ifndef SHIFTMON_RESYNC_EN
    for (int i = 0; i < 5; i++) begin
      idle_cycles(1);
      check("fault_sticky_error", int'(bus.error), 1);
      check("fault_sticky_phase", int'(bus.phase), 2);
    end
`else
    idle_cycles(1);
    check("resync_locked", int'(bus.locked), 1);
    check("resync_phase", int'(bus.phase), 0);
    check("resync_lap", int'(bus.lap_count), 3);
    idle_cycles(5);
`endif

    // Relock on 10100.
    cycle(1'b1, 5'b10100, 5'b00000, 5'b00000);
    idle_cycles(1);
    check("relock_error", int'(bus.error), 0);
    check("relock_locked", int'(bus.locked), 1);
    check("relock_phase", int'(bus.phase), 0);
    check("relock_lap", int'(bus.lap_count), 0);
    idle_cycles(2);

    // Complement rail fault on bit 0.
    cycle(1'b0, 5'b00000, 5'b00000, 5'b00001);
    check("comp_error", int'(bus.error), 1);
    check("comp_locked", int'(bus.locked), 0);

    // Relock, track, then asynchronous reset mid-cycle.
    cycle(1'b1, 5'b01101, 5'b00000, 5'b00000);
    idle_cycles(4);
    check("pre_reset_locked", int'(bus.locked), 1);
    #3;
    clear_ = 1'b0;
    model_reset();
    #1;
    check("async_phase",  int'(bus.phase), 0);
    check("async_lap",    int'(bus.lap_count), 0);
    check("async_locked", int'(bus.locked), 0);
    check("async_error",  int'(bus.error), 0);
    @(negedge clk);
    clear_ = 1'b1;

    // Randomized soak.
    for (int i = 0; i < 1500; i++) begin
      bit         pe;
      logic [4:0] qm, cm;
      pe = ($urandom_range(0, 11) == 0);
      qm = ($urandom_range(0, 24) == 0) ? 5'($urandom_range(1, 31)) : 5'b00000;
      cm = ($urandom_range(0, 24) == 0) ? 5'($urandom_range(1, 31)) : 5'b00000;
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #2;
        clear_ = 1'b0;
        model_reset();
        #1;
        check("rand_reset_locked", int'(bus.locked), 0);
        check("rand_reset_phase", int'(bus.phase), 0);
        @(negedge clk);
        clear_ = 1'b1;
      end
      cycle(pe, 5'($urandom_range(0, 31)), qm, cm);
    end

    cmp_en = 1'b0;
    #20;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
